// File: rtl/debug_hex_writer.sv
// debug_hex_writer: snapshots a flat bus of words and renders each word as
// upper-case hex text plus a trailing space into a terminal text buffer,
// one character per accepted write cycle.
module debug_hex_writer #(
    parameter int WORD_COUNT    = 36,
    parameter int WORD_WIDTH    = 32,
    parameter int WORDS_PER_ROW = 4,
    parameter int COLUMNS       = 80,
    parameter int ADDR_WIDTH    = 12,
    parameter int BASE_ADDR     = 0,
    parameter int CONTINUOUS    = 0
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic [WORD_COUNT*WORD_WIDTH-1:0] words,
    input  logic                             start,
    input  logic                             terminal_ready,
    output logic                             terminal_write,
    output logic [ADDR_WIDTH-1:0]            terminal_addr,
    output logic [7:0]                       terminal_data,
    output logic                             busy,
    output logic                             frame_done
);

    localparam int NIB  = (WORD_WIDTH + 3) / 4;
    localparam int CELL = NIB + 1;
    localparam int KW   = $clog2(CELL);
    localparam int IW   = (WORD_COUNT > 1) ? $clog2(WORD_COUNT) : 1;
    localparam int CW   = (WORDS_PER_ROW > 1) ? $clog2(WORDS_PER_ROW) : 1;

    localparam logic [ADDR_WIDTH-1:0] BASE_A = ADDR_WIDTH'(BASE_ADDR);
    localparam logic [ADDR_WIDTH-1:0] COLS_A = ADDR_WIDTH'(COLUMNS);
    localparam logic [ADDR_WIDTH-1:0] CELL_A = ADDR_WIDTH'(CELL);
    localparam logic [KW-1:0]         K_LAST = KW'(NIB);
    localparam logic [IW-1:0]         W_LAST = IW'(WORD_COUNT - 1);
    localparam logic [CW-1:0]         C_LAST = CW'(WORDS_PER_ROW - 1);

    // A row of cells that overflows the terminal width would overwrite the next row.
    if (WORDS_PER_ROW * CELL > COLUMNS) begin : g_layout_check
        $error("debug_hex_writer: WORDS_PER_ROW*CELL exceeds COLUMNS");
    end
    if (WORD_WIDTH < 1 || WORD_WIDTH > 64) begin : g_width_check
        $error("debug_hex_writer: WORD_WIDTH must be 1..64");
    end

    typedef enum logic [1:0] {IDLE, CAPTURE, EMIT, DONE} state_t;

    state_t                          state_q, state_d;
    logic                            pending_q, pending_d;
    logic [WORD_COUNT*WORD_WIDTH-1:0] shadow_q;
    logic [IW-1:0]                   word_q, word_d;
    logic [KW-1:0]                   k_q, k_d;
    logic [CW-1:0]                   wcol_q, wcol_d;
    logic [ADDR_WIDTH-1:0]           col_q, col_d;
    logic [ADDR_WIDTH-1:0]           row_q, row_d;
    logic                            write_q, write_d;
    logic [ADDR_WIDTH-1:0]           addr_q, addr_d;
    logic [7:0]                      data_q, data_d;

    logic [IW-1:0]         nidx;
    logic [KW-1:0]         nk;
    logic [WORD_WIDTH-1:0] next_word;
    logic [7:0]            next_char;
    logic [7:0]            first_char;

    // Character k of a word: nibble k counted from the MSB of the
    // zero-extended word, or a space for the cell's last position.
    function automatic logic [7:0] char_of(input logic [WORD_WIDTH-1:0] w,
                                           input logic [KW-1:0] k);
        logic [NIB*4-1:0] p;
        logic [3:0]       n;
        p = (NIB*4)'(w);
        n = 4'h0;
        for (int j = 0; j < NIB; j++) begin
            if (int'(k) == NIB - 1 - j) n = p[j*4 +: 4];
        end
        if (k == K_LAST) return 8'h20;
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    endfunction

    // Character that follows the one currently on the bus, from the shadow copy.
    always_comb begin
        nidx      = (k_q == K_LAST) ? word_q + 1'b1 : word_q;
        nk        = (k_q == K_LAST) ? '0 : k_q + 1'b1;
        next_word = '0;
        for (int i = 0; i < WORD_COUNT; i++) begin
            if (int'(nidx) == i) next_word = shadow_q[i*WORD_WIDTH +: WORD_WIDTH];
        end
        next_char  = char_of(next_word, nk);
        // The shadow is being loaded on the same edge, so the first
        // character comes straight from the live bus.
        first_char = char_of(words[WORD_WIDTH-1:0], '0);
    end

    // Next-state and registered-output logic; address uses running accumulators.
    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        word_d    = word_q;
        k_d       = k_q;
        wcol_d    = wcol_q;
        col_d     = col_q;
        row_d     = row_q;
        write_d   = write_q;
        addr_d    = addr_q;
        data_d    = data_q;

        if (start && state_q != IDLE) pending_d = 1'b1;

        case (state_q)
            IDLE: begin
                if (start || pending_q || CONTINUOUS != 0) begin
                    state_d   = CAPTURE;
                    pending_d = 1'b0;
                end
            end
            CAPTURE: begin
                state_d = EMIT;
                word_d  = '0;
                k_d     = '0;
                wcol_d  = '0;
                col_d   = '0;
                row_d   = BASE_A;
                write_d = 1'b1;
                addr_d  = BASE_A;
                data_d  = first_char;
            end
            EMIT: begin
                if (terminal_ready) begin
                    if (k_q != K_LAST) begin
                        k_d    = nk;
                        addr_d = addr_q + 1'b1;
                        data_d = next_char;
                    end else if (word_q == W_LAST) begin
                        state_d = DONE;
                        write_d = 1'b0;
                        addr_d  = '0;
                        data_d  = '0;
                    end else begin
                        word_d = nidx;
                        k_d    = '0;
                        if (wcol_q == C_LAST) begin
                            wcol_d = '0;
                            col_d  = '0;
                            row_d  = row_q + COLS_A;
                        end else begin
                            wcol_d = wcol_q + 1'b1;
                            col_d  = col_q + CELL_A;
                        end
                        addr_d = row_d + col_d;
                        data_d = next_char;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State, counters and output registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            pending_q <= 1'b0;
            word_q    <= '0;
            k_q       <= '0;
            wcol_q    <= '0;
            col_q     <= '0;
            row_q     <= '0;
            write_q   <= 1'b0;
            addr_q    <= '0;
            data_q    <= '0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            word_q    <= word_d;
            k_q       <= k_d;
            wcol_q    <= wcol_d;
            col_q     <= col_d;
            row_q     <= row_d;
            write_q   <= write_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
        end
    end

    // Coherent snapshot: the frame shows the bus as it was in CAPTURE.
    always_ff @(posedge clock) begin
        if (reset)                 shadow_q <= '0;
        else if (state_q == CAPTURE) shadow_q <= words;
    end

    assign terminal_write = write_q;
    assign terminal_addr  = addr_q;
    assign terminal_data  = data_q;
    assign busy           = (state_q != IDLE);
    assign frame_done     = (state_q == DONE);

endmodule

// File: tb/tb_debug_hex_writer.sv
// Scoreboard bench for debug_hex_writer: four instances cover the basic,
// default, odd-width/wrap and continuous configurations.
module tb_debug_hex_writer;

    typedef struct packed {
        logic [11:0] addr;
        logic [7:0]  data;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    int nb_writes = 0;

    exp_t qa[$], qb[$], qc[$], qd[$];

    // A: two 8-bit words, one per row, base 0x100
    logic        rst_a, start_a, rdy_a, wr_a, busy_a, done_a;
    logic [15:0] words_a;
    logic [11:0] addr_a;
    logic [7:0]  data_a;
    // B: default parameters
    logic          rst_b, start_b, rdy_b, wr_b, busy_b, done_b;
    logic [1151:0] words_b;
    logic [11:0]   addr_b;
    logic [7:0]    data_b;
    // C: 5-bit word, 4-bit address wrapping
    logic       rst_c, start_c, rdy_c, wr_c, busy_c, done_c;
    logic [4:0] words_c;
    logic [3:0] addr_c;
    logic [7:0] data_c;
    // D: as A but continuous, start tied low
    logic        rst_d, start_d, rdy_d, wr_d, busy_d, done_d;
    logic [15:0] words_d;
    logic [11:0] addr_d;
    logic [7:0]  data_d;

    debug_hex_writer #(.WORD_COUNT(2), .WORD_WIDTH(8), .WORDS_PER_ROW(1), .COLUMNS(80),
                       .ADDR_WIDTH(12), .BASE_ADDR(256), .CONTINUOUS(0)) u_a (
        .clock(clk), .reset(rst_a), .words(words_a), .start(start_a), .terminal_ready(rdy_a),
        .terminal_write(wr_a), .terminal_addr(addr_a), .terminal_data(data_a),
        .busy(busy_a), .frame_done(done_a));

    debug_hex_writer u_b (
        .clock(clk), .reset(rst_b), .words(words_b), .start(start_b), .terminal_ready(rdy_b),
        .terminal_write(wr_b), .terminal_addr(addr_b), .terminal_data(data_b),
        .busy(busy_b), .frame_done(done_b));

    debug_hex_writer #(.WORD_COUNT(1), .WORD_WIDTH(5), .WORDS_PER_ROW(1), .COLUMNS(80),
                       .ADDR_WIDTH(4), .BASE_ADDR(15), .CONTINUOUS(0)) u_c (
        .clock(clk), .reset(rst_c), .words(words_c), .start(start_c), .terminal_ready(rdy_c),
        .terminal_write(wr_c), .terminal_addr(addr_c), .terminal_data(data_c),
        .busy(busy_c), .frame_done(done_c));

    debug_hex_writer #(.WORD_COUNT(2), .WORD_WIDTH(8), .WORDS_PER_ROW(1), .COLUMNS(80),
                       .ADDR_WIDTH(12), .BASE_ADDR(256), .CONTINUOUS(1)) u_d (
        .clock(clk), .reset(rst_d), .words(words_d), .start(start_d), .terminal_ready(rdy_d),
        .terminal_write(wr_d), .terminal_addr(addr_d), .terminal_data(data_d),
        .busy(busy_d), .frame_done(done_d));

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        chk(nm, {31'd0, act}, {31'd0, exp});
    endtask

    task automatic unexpected(input string nm, input logic [11:0] a, input logic [7:0] d);
        n_chk++;
        n_fail++;
        $display("FAIL %s: unexpected write addr 0x%0h data 0x%0h, expected no write", nm, a, d);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] hexc(input logic [3:0] n);
        string s;
        s = "0123456789ABCDEF";
        return s[n];
    endfunction

    // Words 0xA5 (word 0) and 0x3C (word 1) render as "A5 " at 0x100 and "3C " at 0x150.
    task automatic push_basic(input int which);
        exp_t e[6];
        e[0] = '{12'h100, 8'h41}; e[1] = '{12'h101, 8'h35}; e[2] = '{12'h102, 8'h20};
        e[3] = '{12'h150, 8'h33}; e[4] = '{12'h151, 8'h43}; e[5] = '{12'h152, 8'h20};
        for (int i = 0; i < 6; i++) begin
            if (which == 0) qa.push_back(e[i]);
            else            qd.push_back(e[i]);
        end
    endtask

    // Monitor: every accepted write is popped from its queue and compared.
    always @(negedge clk) begin
        exp_t e;
        if (wr_a && rdy_a) begin
            if (qa.size() == 0) unexpected("a_write", addr_a, data_a);
            else begin
                e = qa.pop_front();
                chk("a_addr", 32'(addr_a), 32'(e.addr));
                chk("a_data", 32'(data_a), 32'(e.data));
            end
        end
        if (wr_b && rdy_b) begin
            nb_writes++;
            if (qb.size() == 0) unexpected("b_write", addr_b, data_b);
            else begin
                e = qb.pop_front();
                chk("b_addr", 32'(addr_b), 32'(e.addr));
                chk("b_data", 32'(data_b), 32'(e.data));
            end
        end
        if (wr_c && rdy_c) begin
            if (qc.size() == 0) unexpected("c_write", {8'h0, addr_c}, data_c);
            else begin
                e = qc.pop_front();
                chk("c_addr", 32'(addr_c), 32'(e.addr));
                chk("c_data", 32'(data_c), 32'(e.data));
            end
        end
        if (wr_d && rdy_d) begin
            if (qd.size() == 0) unexpected("d_write", addr_d, data_d);
            else begin
                e = qd.pop_front();
                chk("d_addr", 32'(addr_d), 32'(e.addr));
                chk("d_data", 32'(data_d), 32'(e.data));
            end
        end
    end

    initial begin
        logic [31:0] wv[36];
        exp_t        e;
        int          guard;
        logic        seen;

        rst_a = 1; rst_b = 1; rst_c = 1; rst_d = 1;
        start_a = 0; start_b = 0; start_c = 0; start_d = 0;
        rdy_a = 1; rdy_b = 1; rdy_c = 1; rdy_d = 1;
        words_a = 16'h3CA5; words_d = 16'h3CA5; words_c = 5'h1F;
        for (int i = 0; i < 36; i++) wv[i] = i * 32'h01010101;
        wv[5] = 32'hDEADBEEF;
        for (int i = 0; i < 36; i++) words_b[i*32 +: 32] = wv[i];

        tick(); tick(); tick();
        // reset state
        chk1("rst_write", wr_a, 1'b0);
        chk("rst_addr", 32'(addr_a), 32'h0);
        chk("rst_data", 32'(data_a), 32'h0);
        chk1("rst_busy", busy_a, 1'b0);
        chk1("rst_done", done_a, 1'b0);
        rst_a = 0; rst_b = 0; rst_c = 0;
        tick();

        // basic frame: CAPTURE in 1, writes 2..7, DONE in 8
        push_basic(0);
        start_a = 1; tick(); start_a = 0;
        for (int c = 1; c <= 9; c++) begin
            chk1($sformatf("t1_busy_c%0d", c), busy_a, c <= 8);
            chk1($sformatf("t1_write_c%0d", c), wr_a, c >= 2 && c <= 7);
            chk1($sformatf("t1_done_c%0d", c), done_a, c == 8);
            tick();
        end
        chk("t1_queue_empty", qa.size(), 0);

        // backpressure on the second character for 3 cycles
        push_basic(0);
        start_a = 1; tick(); start_a = 0;
        for (int c = 1; c <= 12; c++) begin
            rdy_a = !(c >= 3 && c <= 5);
            chk1($sformatf("t2_write_c%0d", c), wr_a, c >= 2 && c <= 10);
            chk1($sformatf("t2_done_c%0d", c), done_a, c == 11);
            if (c >= 3 && c <= 6) begin
                chk($sformatf("t2_hold_addr_c%0d", c), 32'(addr_a), 32'h101);
                chk($sformatf("t2_hold_data_c%0d", c), 32'(data_a), 32'h35);
            end
            tick();
        end
        rdy_a = 1;
        chk("t2_queue_empty", qa.size(), 0);

        // pending: v0 merges two mid-frame starts, v1 starts during DONE
        for (int v = 0; v < 2; v++) begin
            push_basic(0); push_basic(0);
            start_a = 1; tick(); start_a = 0;
            for (int c = 1; c <= 20; c++) begin
                start_a = (v == 0) ? (c == 4 || c == 5) : (c == 8);
                chk1($sformatf("t3v%0d_busy_c%0d", v, c), busy_a,
                     (c >= 1 && c <= 8) || (c >= 10 && c <= 17));
                chk1($sformatf("t3v%0d_write_c%0d", v, c), wr_a,
                     (c >= 2 && c <= 7) || (c >= 11 && c <= 16));
                chk1($sformatf("t3v%0d_done_c%0d", v, c), done_a, c == 8 || c == 17);
                tick();
            end
            start_a = 0;
            chk($sformatf("t3v%0d_queue_empty", v), qa.size(), 0);
        end

        // reset mid-EMIT with a pending start: three writes, then silence
        qa.push_back('{12'h100, 8'h41});
        qa.push_back('{12'h101, 8'h35});
        qa.push_back('{12'h102, 8'h20});
        start_a = 1; tick(); start_a = 0;
        for (int c = 1; c <= 10; c++) begin
            start_a = (c == 3);
            rst_a   = (c == 4);
            if (c >= 2 && c <= 4) chk1($sformatf("t5_write_c%0d", c), wr_a, 1'b1);
            if (c >= 5) begin
                chk1($sformatf("t5_write_c%0d", c), wr_a, 1'b0);
                chk1($sformatf("t5_busy_c%0d", c), busy_a, 1'b0);
                chk1($sformatf("t5_done_c%0d", c), done_a, 1'b0);
            end
            if (c == 5) begin
                chk("t5_addr", 32'(addr_a), 32'h0);
                chk("t5_data", 32'(data_a), 32'h0);
            end
            tick();
        end
        chk("t5_queue_empty", qa.size(), 0);

        // default config: word 5 sits at row 1, column 9 -> addresses 89..97
        for (int i = 0; i < 36; i++) begin
            for (int k = 0; k < 9; k++) begin
                e.addr = 12'((i / 4) * 80 + (i % 4) * 9 + k);
                e.data = (k == 8) ? 8'h20 : hexc(wv[i][31-4*k -: 4]);
                qb.push_back(e);
            end
        end
        start_b = 1; tick(); start_b = 0;
        tick();
        words_b[5*32 +: 32] = 32'h0;   // changed after CAPTURE; must not show
        guard = 0;
        seen  = 0;
        while (!seen && guard < 400) begin
            if (done_b) seen = 1;
            else begin tick(); guard++; end
        end
        chk1("b_frame_done_seen", seen, 1'b1);
        chk("b_write_count", nb_writes, 324);
        chk("b_queue_empty", qb.size(), 0);
        tick();

        // odd width, address wraps past 15
        qc.push_back('{12'd15, 8'h31});
        qc.push_back('{12'd0,  8'h46});
        qc.push_back('{12'd1,  8'h20});
        start_c = 1; tick(); start_c = 0;
        guard = 0;
        seen  = 0;
        while (!seen && guard < 20) begin
            if (done_c) seen = 1;
            else begin tick(); guard++; end
        end
        chk1("c_frame_done_seen", seen, 1'b1);
        chk("c_queue_empty", qc.size(), 0);
        tick();

        // continuous: IDLE(0) CAPTURE(1) writes(2..7) DONE(8) IDLE(9) CAPTURE(10) ...
        push_basic(1); push_basic(1);
        rst_d = 0;
        for (int c = 0; c <= 19; c++) begin
            chk1($sformatf("t8_busy_c%0d", c), busy_d,
                 (c >= 1 && c <= 8) || (c >= 10 && c <= 17) || c == 19);
            chk1($sformatf("t8_done_c%0d", c), done_d, c == 8 || c == 17);
            chk1($sformatf("t8_write_c%0d", c), wr_d,
                 (c >= 2 && c <= 7) || (c >= 11 && c <= 16));
            if (c == 19) rst_d = 1;
            tick();
        end
        chk("t8_queue_empty", qd.size(), 0);
        tick(); tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
